calc_entry_sequencer: RTL



---
 rtl/calc_entry_sequencer.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/calc_entry_sequencer.sv
// Keypad entry sequencer for the 4-bit calculator: collects A, operator, B,
// holds them for the datapath, captures the BCD result after a fixed latency.
module calc_entry_sequencer #(
    parameter int unsigned RESULT_LAT   = 3,
    parameter int unsigned SHOW_TIMEOUT = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic [3:0] o_num1,
    output logic [3:0] o_num2,
    output logic [3:0] o_op,
    input  logic [3:0] i_tens,
    input  logic [3:0] i_ones,
    output logic [3:0] res_tens,
    output logic [3:0] res_ones,
    output logic       res_valid,
    output logic       err,
    output logic       busy,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GOT_A  = 3'd1,
        GOT_OP = 3'd2,
        GOT_B  = 3'd3,
        CALC   = 3'd4,
        SHOW   = 3'd5
    } state_e;

    localparam logic [3:0]  KEY_CLR   = 4'hC;
    localparam logic [3:0]  KEY_EQ    = 4'hB;
    localparam logic [3:0]  KEY_NOP   = 4'hA;
    localparam logic [3:0]  LAT_INIT  = 4'(RESULT_LAT - 1);
    localparam logic [31:0] SHOW_LAST = (SHOW_TIMEOUT == 0) ? 32'd0 : 32'(SHOW_TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [3:0]  num1_q, num1_d, num2_q, num2_d, op_q, op_d;
    logic [3:0]  res_tens_q, res_tens_d, res_ones_q, res_ones_d;
    logic        res_valid_q, res_valid_d, err_q, err_d;
    logic [3:0]  lat_cnt_q, lat_cnt_d;
    logic [31:0] show_cnt_q, show_cnt_d;

    logic accept, is_digit, is_op, is_clr, is_eq, do_clear;

    // 0xA behaves exactly like no key at all, including for the SHOW timeout.
    assign accept   = key_valid && (key_code != KEY_NOP);
    assign is_digit = key_code <= 4'd9;
    assign is_op    = (key_code == 4'hF) || (key_code == 4'hE) || (key_code == 4'hD);
    assign is_clr   = key_code == KEY_CLR;
    assign is_eq    = key_code == KEY_EQ;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_d     = state_q;
        num1_d      = num1_q;
        num2_d      = num2_q;
        op_d        = op_q;
        res_tens_d  = res_tens_q;
        res_ones_d  = res_ones_q;
        res_valid_d = res_valid_q;
        err_d       = err_q;
        lat_cnt_d   = lat_cnt_q;
        show_cnt_d  = '0;
        do_clear    = accept && is_clr && (state_q != CALC);

        case (state_q)
            IDLE: begin
                if (accept && is_digit) begin
                    num1_d  = key_code;
                    state_d = GOT_A;
                end
            end
            GOT_A: begin
                if (accept && is_digit) begin
                    num1_d = key_code;
                end else if (accept && is_op) begin
                    op_d    = key_code;
                    state_d = GOT_OP;
                end
            end
            GOT_OP: begin
                if (accept && is_op) begin
                    op_d = key_code;
                end else if (accept && is_digit) begin
                    num2_d  = key_code;
                    state_d = GOT_B;
                end
            end
            GOT_B: begin
                if (accept && is_digit) begin
                    num2_d = key_code;
                end else if (accept && is_eq) begin
                    lat_cnt_d = LAT_INIT;
                    state_d   = CALC;
                end
            end
            CALC: begin
                if (lat_cnt_q == '0) begin
                    res_tens_d  = i_tens;
                    res_ones_d  = i_ones;
                    res_valid_d = 1'b1;
                    err_d       = (i_tens == 4'd9) && (i_ones == 4'd9);
                    state_d     = SHOW;
                end else begin
                    lat_cnt_d = lat_cnt_q - 4'd1;
                end
            end
            SHOW: begin
                if (SHOW_TIMEOUT != 0) show_cnt_d = show_cnt_q + 32'd1;
                if (accept && is_digit) begin
                    num1_d      = key_code;
                    num2_d      = '0;
                    op_d        = KEY_CLR;
                    res_valid_d = 1'b0;
                    err_d       = 1'b0;
                    state_d     = GOT_A;
                end else if (!accept && (SHOW_TIMEOUT != 0) && (show_cnt_q >= SHOW_LAST)) begin
                    do_clear = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (do_clear) begin
            state_d     = IDLE;
            num1_d      = '0;
            num2_d      = '0;
            op_d        = KEY_CLR;
            res_tens_d  = '0;
            res_ones_d  = '0;
            res_valid_d = 1'b0;
            err_d       = 1'b0;
            show_cnt_d  = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is synchronous here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            num1_q      <= '0;
            num2_q      <= '0;
            op_q        <= KEY_CLR;
            res_tens_q  <= '0;
            res_ones_q  <= '0;
            res_valid_q <= 1'b0;
            err_q       <= 1'b0;
            lat_cnt_q   <= '0;
            show_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            num1_q      <= num1_d;
            num2_q      <= num2_d;
            op_q        <= op_d;
            res_tens_q  <= res_tens_d;
            res_ones_q  <= res_ones_d;
            res_valid_q <= res_valid_d;
            err_q       <= err_d;
            lat_cnt_q   <= lat_cnt_d;
            show_cnt_q  <= show_cnt_d;
        end
    end

    assign o_num1    = num1_q;
    assign o_num2    = num2_q;
    assign o_op      = op_q;
    assign res_tens  = res_tens_q;
    assign res_ones  = res_ones_q;
    assign res_valid = res_valid_q;
    assign err       = err_q;
    assign busy      = (state_q == CALC);
    assign state     = state_q;

endmodule
